lfsr_keystream_ctrl: RTL and testbench
======================================

LFSR_KEYSTREAM_CTRL -- requirements
Module: lfsr_keystream_ctrl

Interface
REQ-001 Parameter WORD_W, default 32, sets the output word width; legal range 1..64.
REQ-002 Parameter WARMUP, default 256, sets the number of discarded LFSR steps after each seed load; legal range 0..4095.
REQ-003 Port i_clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-004 Port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port i_seed, input, 128 bits: seed value.
REQ-006 Port i_seed_valid, input, 1 bit: seed load request.
REQ-007 Port o_seed_ready, output, 1 bit: controller accepts a seed.
REQ-008 Port o_word, output, WORD_W bits: packed keystream word.
REQ-009 Port o_word_valid, output, 1 bit: o_word is valid.
REQ-010 Port i_word_ready, input, 1 bit: consumer accepts o_word.
REQ-011 Port o_busy, output, 1 bit: high in WARMUP or FILL.
REQ-012 Port o_lfsr, output, 128 bits: current LFSR state, for debug.
REQ-013 Port o_seed_err, output, 1 bit: zero-seed flag; present only with the macro defined (see REQ-031).

Function
REQ-014 The LFSR step SHALL be lfsr <= {lfsr[127]^lfsr[6]^lfsr[1]^lfsr[0], lfsr[127:1]}; the keystream bit of a step is lfsr[0] before that step.
REQ-015 The LFSR SHALL step only in the WARMUP and FILL states, and SHALL hold its value in all other states.
REQ-016 The FSM SHALL have exactly four states: IDLE, WARMUP, FILL and PRESENT.
REQ-017 o_seed_ready SHALL equal 1 in every state; a seed is accepted on any edge where i_seed_valid=1.
REQ-018 On an accepted seed (edge E0):
- lfsr <= i_seed and step counter <= 0;
- o_word_valid <= 0, discarding any pending word;
- next state is WARMUP, or FILL if WARMUP=0.
REQ-019 WARMUP SHALL take exactly WARMUP steps at edges E1..E_WARMUP, then move to FILL.
REQ-020 FILL SHALL take exactly WORD_W steps; the k-th emitted bit (k=0 first) SHALL be written to o_word[k].
REQ-021 On the last FILL edge, o_word SHALL be updated and o_word_valid <= 1; the state then moves to PRESENT.
REQ-022 First-word latency: o_word_valid SHALL rise at edge E0+WARMUP+WORD_W.
REQ-023 In PRESENT, o_word and o_word_valid SHALL hold stable until i_word_ready=1.
REQ-024 On an edge in PRESENT with i_word_ready=1:
- o_word_valid <= 0;
- next state is FILL;
- the next word becomes valid WORD_W edges later.
REQ-025 Word throughput SHALL be one word per WORD_W+1 cycles when i_word_ready is held at 1.
REQ-026 i_seed_valid=1 and i_word_ready=1 on the same PRESENT edge: the word counts as consumed and the seed load (REQ-018) SHALL take effect.
REQ-027 A seed accepted in WARMUP or FILL SHALL restart the sequence from REQ-018; any partial word is discarded.
REQ-028 IDLE: no stepping, o_word_valid=0; i_word_ready SHALL be ignored in every state except PRESENT.
REQ-029 The step counter SHALL be sized to hold max(WARMUP, WORD_W) without wrap-around.

Reset
REQ-030 While i_reset_n=0, the block SHALL hold:
- state=IDLE, lfsr=0, counter=0;
- o_word=0, o_word_valid=0, o_busy=0;
- o_seed_err=0 (when present).
REQ-030 (cont.) The first seed SHALL be accepted on the first rising edge after i_reset_n deasserts.

Configuration
REQ-031 Macro LFSR_CTRL_ZERO_SEED_GUARD_EN, when defined:
- an accepted seed of all zeros SHALL load lfsr <= 128'h1 and set o_seed_err <= 1;
- o_seed_err SHALL be cleared by the next accepted nonzero seed or by reset.
REQ-032 Without the macro:
- the o_seed_err port SHALL NOT exist;
- a zero seed SHALL load 0, and every subsequent word SHALL be 0.

Verification
REQ-033 WORD_W=8, WARMUP=0, seed=128'hA5, i_word_ready=1 -> o_word_valid rises 8 edges after seed accept, first word = 8'hA5.
REQ-034 WORD_W=8, WARMUP=0, seed=128'h1 -> words 8'h01 then 8'h00; second o_word_valid rises 9 edges after the first.
REQ-035 WORD_W=8, WARMUP=0, seed=128'h1, i_word_ready=0 for 20 cycles -> o_word holds 8'h01 and o_word_valid stays 1 with no stepping; then i_word_ready=1 together with seed=128'h3C -> next word 8'h3C.
REQ-036 WARMUP=4, WORD_W=8, seed=128'h1, new seed 128'hFF asserted mid-FILL -> o_word_valid stays 0 and the first valid word is seed 128'hFF's word 8'h0F (bits 4..11 of seed), 12 edges after the reseed.
REQ-037 i_reset_n pulsed low mid-FILL -> all outputs return to reset values immediately (asynchronously); state IDLE, with no word until the next seed.
REQ-038 Seed=0 with the macro -> o_seed_err=1 and o_lfsr=128'h1 after E0; without the macro -> all words 0.

Source files
------------

// File: rtl/lfsr_keystream_ctrl.sv
// 128-bit Fibonacci LFSR keystream controller: seed load, warm-up discard, word packing.
// Optional zero-seed guard enabled with macro LFSR_CTRL_ZERO_SEED_GUARD_EN.
module lfsr_keystream_ctrl #(
  parameter int WORD_W = 32,
  parameter int WARMUP = 256
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [127:0]      i_seed,
  input  logic              i_seed_valid,
  output logic              o_seed_ready,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic              o_busy,
  output logic [127:0]      o_lfsr
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
  ,
  output logic              o_seed_err
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_FILL    = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  localparam int CNT_MAX = (WARMUP > WORD_W) ? WARMUP : WORD_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORD_W - 1);

  function automatic logic [127:0] lfsr_next(input logic [127:0] s);
    return {s[127] ^ s[6] ^ s[1] ^ s[0], s[127:1]};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [127:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
  logic              seed_err_q, seed_err_d;
`endif

  // Next-state logic; a seed request overrides whatever the FSM is doing.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    word_d  = word_q;
    valid_d = valid_q;
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
    seed_err_d = seed_err_q;
`endif
    if (i_seed_valid) begin
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
      if (i_seed == 128'd0) begin
        lfsr_d     = 128'd1;
        seed_err_d = 1'b1;
      end else begin
        lfsr_d     = i_seed;
        seed_err_d = 1'b0;
      end
`else
      lfsr_d = i_seed;
`endif
      cnt_d   = '0;
      fill_d  = '0;
      valid_d = 1'b0;
      state_d = (WARMUP == 0) ? S_FILL : S_WARMUP;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_WARMUP: begin
          lfsr_d = lfsr_next(lfsr_q);
          if (cnt_q == WARM_LAST) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_FILL: begin
          lfsr_d = lfsr_next(lfsr_q);
          // Bit k of the word is the k-th bit shifted out during this fill.
          for (int i = 0; i < WORD_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              fill_d[i] = lfsr_q[0];
            end else begin
              fill_d[i] = fill_q[i];
            end
          end
          if (cnt_q == FILL_LAST) begin
            cnt_d   = '0;
            word_d  = fill_d;
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PRESENT: begin
          if (i_word_ready) begin
            valid_d = 1'b0;
            state_d = S_FILL;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    busy_d = (state_d == S_WARMUP) || (state_d == S_FILL);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 128'd0;
      cnt_q   <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
  // Sticky zero-seed flag, cleared by a nonzero seed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= seed_err_d;
    end
  end
  assign o_seed_err = seed_err_q;
`endif

  assign o_seed_ready = 1'b1;
  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_lfsr       = lfsr_q;

endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
// Scoreboard bench: two instances (WORD_W=8 with WARMUP=0 and WARMUP=4), directed seeds.
module tb_lfsr_keystream_ctrl;

  typedef struct {
    logic [7:0] w;
    int         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] seed0 = '0, seed1 = '0;
  logic         sv0 = 1'b0, sv1 = 1'b0;
  logic         rdy0 = 1'b0, rdy1 = 1'b0;
  logic         sr0, sr1, wv0, wv1, busy0, busy1;
  logic [7:0]   word0, word1;
  logic [127:0] lfsr0, lfsr1;
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
  logic         err0, err1;
`endif

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic held0 = 1'b0, held1 = 1'b0;

  lfsr_keystream_ctrl #(.WORD_W(8), .WARMUP(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_seed(seed0), .i_seed_valid(sv0),
    .o_seed_ready(sr0), .o_word(word0), .o_word_valid(wv0), .i_word_ready(rdy0),
    .o_busy(busy0), .o_lfsr(lfsr0)
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
    , .o_seed_err(err0)
`endif
  );

  lfsr_keystream_ctrl #(.WORD_W(8), .WARMUP(4)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_seed(seed1), .i_seed_valid(sv1),
    .o_seed_ready(sr1), .o_word(word1), .o_word_valid(wv1), .i_word_ready(rdy1),
    .o_busy(busy1), .o_lfsr(lfsr1)
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
    , .o_seed_err(err1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] step(input logic [127:0] s);
    return {s[127] ^ s[6] ^ s[1] ^ s[0], s[127:1]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load0(input logic [127:0] v, output int e);
    e = cyc + 1;
    seed0 = v;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    seed0 = '0;
  endtask

  task automatic load1(input logic [127:0] v, output int e);
    e = cyc + 1;
    seed1 = v;
    sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    seed1 = '0;
  endtask

  // Monitor for dut0: each newly presented word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held0 = 1'b0;
    end else begin
      if (wv0 && !held0) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0_unexpected_word: got %0h expected no word (cycle %0d)", word0, cyc);
        end else begin
          e = q0.pop_front();
          chk("dut0_word", 128'(word0), 128'(e.w));
          chk("dut0_latency", 128'(cyc), 128'(e.c));
        end
        held0 = 1'b1;
      end
      if ((wv0 && rdy0) || sv0) held0 = 1'b0;
    end
  end

  // Monitor for dut1.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held1 = 1'b0;
    end else begin
      if (wv1 && !held1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1_unexpected_word: got %0h expected no word (cycle %0d)", word1, cyc);
        end else begin
          e = q1.pop_front();
          chk("dut1_word", 128'(word1), 128'(e.w));
          chk("dut1_latency", 128'(cyc), 128'(e.c));
        end
        held1 = 1'b1;
      end
      if ((wv1 && rdy1) || sv1) held1 = 1'b0;
    end
  end

  initial begin
    int e0;
    int e1;
    logic [127:0] lexp;

    // Reset state
    repeat (3) tick();
    chk("rst_word", 128'(word0), 128'd0);
    chk("rst_valid", 128'(wv0), 128'd0);
    chk("rst_busy", 128'(busy0), 128'd0);
    chk("rst_lfsr", lfsr0, 128'd0);
    chk("rst_seed_ready", 128'(sr0), 128'd1);

    // Seed A5 on the very first edge after reset release, ready held high
    @(negedge clk);
    rst_n = 1'b1;
    rdy0 = 1'b1;
    seed0 = 128'hA5;
    sv0 = 1'b1;
    e0 = cyc + 1;
    tick();
    sv0 = 1'b0;
    seed0 = '0;
    chk("a5_lfsr_load", lfsr0, 128'hA5);
    chk("a5_busy", 128'(busy0), 128'd1);
    q0.push_back('{w: 8'hA5, c: e0 + 8});
    q0.push_back('{w: 8'h00, c: e0 + 17});
    q0.push_back('{w: 8'h00, c: e0 + 26});
    wait_until(e0 + 26);

    // Seed 1: words 01 then 00, nine edges apart
    load0(128'h1, e0);
    q0.push_back('{w: 8'h01, c: e0 + 8});
    q0.push_back('{w: 8'h00, c: e0 + 17});
    wait_until(e0 + 17);

    // Seed 1 with consumer stalled: word and LFSR must hold
    rdy0 = 1'b0;
    load0(128'h1, e0);
    q0.push_back('{w: 8'h01, c: e0 + 8});
    lexp = 128'h1;
    for (int i = 0; i < 8; i++) lexp = step(lexp);
    wait_until(e0 + 8);
    for (int i = 0; i < 20; i++) begin
      chk("stall_word", 128'(word0), 128'h01);
      chk("stall_valid", 128'(wv0), 128'd1);
      chk("stall_lfsr", lfsr0, lexp);
      tick();
    end

    // Consume and reseed on the same edge
    rdy0 = 1'b1;
    load0(128'h3C, e0);
    rdy0 = 1'b0;
    q0.push_back('{w: 8'h3C, c: e0 + 8});
    wait_until(e0 + 10);
    chk("3c_hold_valid", 128'(wv0), 128'd1);

    // Asynchronous reset in the middle of a fill
    load0(128'hA5, e0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(wv0), 128'd0);
    chk("arst_word", 128'(word0), 128'd0);
    chk("arst_busy", 128'(busy0), 128'd0);
    chk("arst_lfsr", lfsr0, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) tick();
    chk("idle_valid", 128'(wv0), 128'd0);
    chk("idle_lfsr", lfsr0, 128'd0);
    chk("idle_busy", 128'(busy0), 128'd0);

    // WARMUP=4: reseed with FF mid-fill of a seed-1 run
    rdy1 = 1'b1;
    load1(128'h1, e1);
    chk("w4_busy_warm", 128'(busy1), 128'd1);
    repeat (6) tick();
    load1(128'hFF, e1);
    chk("w4_reseed_lfsr", lfsr1, 128'hFF);
    q1.push_back('{w: 8'h0F, c: e1 + 12});
    wait_until(e1 + 12);

    // Zero seed
    load1(128'h0, e1);
`ifdef LFSR_CTRL_ZERO_SEED_GUARD_EN
    chk("zero_seed_err", 128'(err1), 128'd1);
    chk("zero_seed_lfsr", lfsr1, 128'h1);
`else
    chk("zero_seed_lfsr", lfsr1, 128'h0);
`endif
    q1.push_back('{w: 8'h00, c: e1 + 12});
    q1.push_back('{w: 8'h00, c: e1 + 21});
    wait_until(e1 + 23);
    rdy1 = 1'b0;
    tick();

    chk("dut0_queue_empty", 128'(q0.size()), 128'd0);
    chk("dut1_queue_empty", 128'(q1.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
